// File: rtl/casex_log_pkg.sv
// Shared types and helpers for the casex result logger: legal result codes,
// tracker state encoding and the legality check.
package casex_log_pkg;

  localparam logic [3:0] RES_ZERO = 4'b0000;
  localparam logic [3:0] RES_ONE  = 4'b0001;
  localparam logic [3:0] RES_TWO  = 4'b0010;

  typedef enum logic {
    IDLE,
    TRACK
  } track_state_e;

  // Uses ==, so any X/Z bit makes the result unknown and the caller's
  // if/else falls through to the illegal branch.
  function automatic logic is_legal(input logic [3:0] code);
    return (code == RES_ZERO) || (code == RES_ONE) || (code == RES_TWO);
  endfunction

endpackage

// File: rtl/casex_log_fifo.sv
// Synchronous FIFO with a combinational head read. The caller decides
// legality: it never pushes when full unless it pops in the same cycle.
module casex_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers is enough
  // to make old contents unreachable, and it keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/casex_result_logger.sv
// Consumes casex decode results: filters repeats, timestamps changes into a
// FIFO, counts accepted results and flags illegal codes and lost entries.
module casex_result_logger
  import casex_log_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       in_code,
  input  logic             in_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_code,
  output logic [TS_W-1:0]  out_ts,
  output logic [CNT_W-1:0] cnt_zero,
  output logic [CNT_W-1:0] cnt_one,
  output logic [CNT_W-1:0] cnt_two,
  output logic             illegal_seen,
  output logic             overflow
);

  localparam int EW = 4 + TS_W;

  track_state_e    state_q, state_d;
  logic [3:0]      last_q, last_d;
  logic [TS_W-1:0] ts_q;

  logic          accept;
  logic          illegal;
  logic          pop;
  logic          push;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_head;

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches leaves it unassigned and no latch is inferred.
  always_comb begin
    accept  = 1'b0;
    illegal = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    if (in_valid) begin
      if (is_legal(in_code)) begin
        if (state_q == IDLE || in_code != last_q) accept = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end
    if (accept) begin
      state_d = TRACK;
      last_d  = in_code;
    end
  end

  // A full FIFO can still take an entry when the head leaves in the same cycle.
  assign pop  = !fifo_empty && out_ready;
  assign push = accept && (!fifo_full || pop);
  assign drop = accept && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= RES_ZERO;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ts_q    <= ts_q + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_zero     <= '0;
      cnt_one      <= '0;
      cnt_two      <= '0;
      illegal_seen <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (illegal) illegal_seen <= 1'b1;
      if (drop)    overflow     <= 1'b1;
      if (accept) begin
        case (in_code)
          RES_ZERO: if (cnt_zero != '1) cnt_zero <= cnt_zero + CNT_W'(1);
          RES_ONE:  if (cnt_one  != '1) cnt_one  <= cnt_one  + CNT_W'(1);
          RES_TWO:  if (cnt_two  != '1) cnt_two  <= cnt_two  + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  casex_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({in_code, ts_q}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // The RAM head is stale when empty, so the outputs are forced to zero.
  assign out_valid = !fifo_empty;
  assign out_code  = fifo_empty ? 4'b0000 : fifo_head[EW-1 -: 4];
  assign out_ts    = fifo_empty ? '0 : fifo_head[TS_W-1:0];

endmodule

// File: tb/tb_casex_result_logger.sv
// Cycle-level scoreboard bench for casex_result_logger: a reference model
// queues expected entries as stimulus is driven and every output is compared.
module tb_casex_result_logger;

  localparam int DEPTH = 4;
  localparam int TS_W  = 8;
  localparam int CNT_W = 2;
  localparam int EW    = 4 + TS_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       in_code;
  logic             in_valid;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_code;
  logic [TS_W-1:0]  out_ts;
  logic [CNT_W-1:0] cnt_zero;
  logic [CNT_W-1:0] cnt_one;
  logic [CNT_W-1:0] cnt_two;
  logic             illegal_seen;
  logic             overflow;

  casex_result_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_code      (in_code),
    .in_valid     (in_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_ts       (out_ts),
    .cnt_zero     (cnt_zero),
    .cnt_one      (cnt_one),
    .cnt_two      (cnt_two),
    .illegal_seen (illegal_seen),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [EW-1:0]    m_q[$];
  logic [TS_W-1:0]  m_ts;
  logic             m_track;
  logic [3:0]       m_last;
  logic [CNT_W-1:0] m_cz, m_co, m_ct;
  logic             m_ill, m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    e = '0;
    if (m_q.size() != 0) e = m_q[0];
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("out_code", 32'(out_code), 32'(e[EW-1 -: 4]));
    check("out_ts", 32'(out_ts), 32'(e[TS_W-1:0]));
    check("cnt_zero", 32'(cnt_zero), 32'(m_cz));
    check("cnt_one", 32'(cnt_one), 32'(m_co));
    check("cnt_two", 32'(cnt_two), 32'(m_ct));
    check("illegal_seen", 32'(illegal_seen), 32'(m_ill));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] code, input logic rdy);
    logic legal, acc, pp;
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_code   = code;
    out_ready = rdy;
    if (rst) begin
      m_q.delete();
      m_ts = '0; m_track = 1'b0; m_last = 4'b0000;
      m_cz = '0; m_co = '0; m_ct = '0; m_ill = 1'b0; m_ovf = 1'b0;
    end else begin
      legal = (in_code === 4'b0000) || (in_code === 4'b0001) || (in_code === 4'b0010);
      acc   = v && legal && (!m_track || in_code !== m_last);
      pp    = (m_q.size() != 0) && rdy;
      if (v && !legal) m_ill = 1'b1;
      if (pp) void'(m_q.pop_front());
      if (acc) begin
        if (m_q.size() < DEPTH) m_q.push_back({in_code, m_ts});
        else m_ovf = 1'b1;
        if (in_code === 4'b0000 && m_cz != '1) m_cz = m_cz + 1'b1;
        if (in_code === 4'b0001 && m_co != '1) m_co = m_co + 1'b1;
        if (in_code === 4'b0010 && m_ct != '1) m_ct = m_ct + 1'b1;
        m_track = 1'b1;
        m_last  = in_code;
      end
      m_ts = m_ts + 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_code = 4'b0000; out_ready = 1'b0;
    do_reset();
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cnt_zero", 32'(cnt_zero), 32'd0);

    // Held 0000 logs exactly one entry at ts=0
    step(1'b0, 1'b1, 4'b0000, 1'b1);
    check("hold_head_ts", 32'(out_ts), 32'd0);
    check("hold_head_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0000, 1'b1);
    check("hold_cnt_zero", 32'(cnt_zero), 32'd1);
    check("hold_drained", 32'(out_valid), 32'd0);

    // Change sequence from ts=0, then drain
    do_reset();
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 1'b0);
    step(1'b0, 1'b1, 4'b0001, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    check("seq_cnt_two", 32'(cnt_two), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, 1'b1);

    // Illegal codes, then a legal one is still accepted
    do_reset();
    step(1'b0, 1'b1, 4'b0111, 1'b0);
    check("ill_flag", 32'(illegal_seen), 32'd1);
    check("ill_no_entry", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 4'b00x1, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 1'b0);
    check("ill_then_zero", 32'(cnt_zero), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000, 1'b1);

    // Overflow: DEPTH+2 changes with reader stalled, then drain
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, (i % 2) ? 4'b0001 : 4'b0000, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_counts", 32'(cnt_zero) + 32'(cnt_one), 32'd6);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 4'b0000, 1'b1);

    // Full FIFO with accept and pop together keeps occupancy at DEPTH
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, (i % 2) ? 4'b0001 : 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 1'b1);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 4'b0000, 1'b1);

    // Saturation at CNT_W=2, then reset mid-stream
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, (i % 2) ? 4'b0001 : 4'b0000, 1'b1);
    step(1'b0, 1'b1, 4'b0010, 1'b1);
    check("sat_zero", 32'(cnt_zero), 32'd3);
    check("sat_one", 32'(cnt_one), 32'd3);
    step(1'b0, 1'b1, 4'b0111, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 1'b0);
    check("midrst_cnt", 32'(cnt_zero), 32'd0);
    check("midrst_ill", 32'(illegal_seen), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);

    // Timestamp wraps modulo 2^TS_W
    for (int i = 0; i < 258; i++) step(1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    check("wrap_ts", 32'(out_ts), 32'd2);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/casex_result_logger.md
# casex_result_logger

Clocked consumer for the 4-bit result code produced by the casex decode stage (legal results 4'b0000, 4'b0001, 4'b0010). It filters repeats, timestamps every change of result, buffers (code, timestamp) pairs in a small FIFO drained by a valid/ready reader, and keeps per-result occurrence counters. Illegal codes and FIFO overflow are reported as sticky flags. It sits directly downstream of the decoder and is the self-check point for it.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- TS_W, 8, timestamp width
- CNT_W, 8, per-result counter width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_code  in  4  result code from decode stage
- in_valid  in  1  in_code is meaningful this cycle
- out_valid  out  1  FIFO head present
- out_ready  in  1  reader accepts head
- out_code  out  4  head result code; 0 when empty
- out_ts  out  TS_W  head timestamp; 0 when empty
- cnt_zero / cnt_one / cnt_two  out  CNT_W each  accepted-change counts per result
- illegal_seen  out  1  sticky: illegal code sampled
- overflow  out  1  sticky: legal change dropped because FIFO full

## Operation
- Reset: every output 0; FIFO empty; timestamp counter 0; tracker in state IDLE.
- Timestamp counter: +1 every cycle when reset=0, wraps modulo 2^TS_W.
- Legal = in_code matches 4'b0000, 4'b0001 or 4'b0010 exactly. X/Z bits count as illegal.
- Tracker states:
  - IDLE: no code accepted yet. Legal valid sample -> accept -> TRACK.
  - TRACK: holds last_code. Legal valid sample with in_code != last_code -> accept. Equal code -> ignore.
- Accept: push {in_code, current timestamp}; increment the matching counter, saturating at all-ones; last_code <= in_code.
- Illegal valid sample: illegal_seen <= 1. No push, no count, state and last_code unchanged.
- in_valid=0: nothing sampled.
- Pop: out_valid && out_ready removes the head.
- Full and accept without pop: entry dropped, overflow <= 1. Counter and last_code still update.
- Full and accept with pop in the same cycle: both take effect and occupancy stays DEPTH.
- Empty and accept with out_ready=1: no bypass; entry becomes visible next cycle.
- Sticky flags clear only on reset.
- Reset mid-operation: all state lost, including FIFO contents, flags and counters.

## Timing
- Accept in cycle N -> entry visible on out_* at cycle N+1, if it is at the head.
- The logged timestamp is the counter value in cycle N. The first cycle after reset deasserts logs ts=0.
- Counters and flags update in the cycle after the sampling edge, i.e. they are registered.
- Throughput: one accept and one pop per cycle.
- out_code/out_ts are stable while out_valid=1 and out_ready=0.

## Structure
- Package casex_log_pkg holds:
  - result constants RES_ZERO=4'b0000, RES_ONE=4'b0001, RES_TWO=4'b0010
  - tracker state enum {IDLE, TRACK}
  - function is_legal(code)
- Sub-module casex_log_fifo: parameterized synchronous FIFO (DEPTH, width 4+TS_W).
  - ports: push, pop, full, empty, head data
  - zero-output-when-empty handled at top level
- Top level holds the tracker FSM, timestamp counter, saturating counters and flags.

## Test plan
- Reset, then in_valid=1 with 0000 held 5 cycles, out_ready=1 -> exactly one entry {0000, ts=0}; cnt_zero=1.
- Sequence 0000, 0001, 0001, 0010 on consecutive cycles from ts=0 -> entries (0000,0), (0001,1), (0010,3); cnts 1/1/1.
- 4'b0111, then 4'b00x1 -> illegal_seen=1; no entries; counters unchanged; a following 0000 is still accepted.
- out_ready=0, DEPTH+2 alternating 0000/0001 changes -> out_valid=1 with 4 entries; overflow=1; cnt_zero+cnt_one=6; draining returns the first 4 in order.
- FIFO full, accept and pop in the same cycle -> occupancy stays 4; overflow stays 0.
- CNT_W=2, alternate 0000/0001 8 times -> both counters saturate at 3. Assert reset mid-stream -> all outputs 0 the next cycle.
